// File: rtl/fetch_unit.sv
// Instruction fetch front end: sequential PC, one-cycle squash on redirect, stall hold.
// Optional FETCH_PERF_CNT_EN adds saturating fetch/bubble counters.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned IMEM_AW  = 12
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               stall,
    input  logic               redirect_valid,
    input  logic [31:0]        redirect_pc,
    output logic [IMEM_AW-1:0] imem_addr,
    input  logic [31:0]        imem_q,
    output logic [31:0]        insn_out,
    output logic [31:0]        pc_out,
    output logic [31:0]        pc_1,
    output logic               insn_valid
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]        fetch_count,
    output logic [31:0]        bubble_count
`endif
);

    typedef enum logic [1:0] {StFill, StRun, StBubble} state_e;

    state_e      state_q, state_d;
    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic [31:0] pc_out_q, pc_out_d;
    logic [31:0] insn_q;
    logic        held_q, held_d;

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        pc_out_d   = pc_out_q;
        held_d     = 1'b0;
        unique case (state_q)
            StFill: begin
                if (!stall) begin
                    state_d    = StRun;
                    fetch_pc_d = fetch_pc_q + 32'd1;
                    pc_out_d   = fetch_pc_q;
                end
            end
            StRun: begin
                if (redirect_valid) begin
                    state_d    = StBubble;
                    fetch_pc_d = redirect_pc;
                end else if (!stall) begin
                    fetch_pc_d = fetch_pc_q + 32'd1;
                    pc_out_d   = fetch_pc_q;
                end else begin
                    // ROM keeps reading the next address while stalled, so freeze the output word
                    held_d = 1'b1;
                end
            end
            StBubble: begin
                if (redirect_valid) begin
                    fetch_pc_d = redirect_pc;
                end else if (!stall) begin
                    state_d    = StRun;
                    fetch_pc_d = fetch_pc_q + 32'd1;
                    pc_out_d   = fetch_pc_q;
                end
            end
            default: state_d = StFill;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= StFill;
            fetch_pc_q <= RESET_PC;
            pc_out_q   <= RESET_PC;
            insn_q     <= 32'd0;
            held_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            pc_out_q   <= pc_out_d;
            insn_q     <= insn_out;
            held_q     <= held_d;
        end
    end

    // The ROM's output register holds the live word; insn_q covers stalls, fill and bubbles
    assign insn_out   = (state_q == StRun && !held_q) ? imem_q : insn_q;
    assign insn_valid = (state_q == StRun);
    assign pc_out     = pc_out_q;
    assign pc_1       = pc_out_q + 32'd1;
    assign imem_addr  = fetch_pc_q[IMEM_AW-1:0];

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_count_q, bubble_count_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            fetch_count_q  <= 32'd0;
            bubble_count_q <= 32'd0;
        end else begin
            if (insn_valid && !stall && fetch_count_q != 32'hFFFF_FFFF) begin
                fetch_count_q <= fetch_count_q + 32'd1;
            end
            if (state_q == StBubble && !stall && bubble_count_q != 32'hFFFF_FFFF) begin
                bubble_count_q <= bubble_count_q + 32'd1;
            end
        end
    end

    assign fetch_count  = fetch_count_q;
    assign bubble_count = bubble_count_q;
`endif

endmodule
